// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, LSB first, one result bit per clock
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in, using a single full-adder
//   cell over WIDTH clock cycles. The operands, the carry and the result are held in
//   shift registers. The result stays on sum/cout until the next operation is accepted.
//
// Ports:
//   clk    in   1      rising-edge clock for all state
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition; accepted only while busy=0 (IDLE or DONE)
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while bits are being processed (SHIFT state)
//   done   out  1      one-cycle pulse, result on sum/cout is complete
//   sum    out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout   out  1      carry out of bit WIDTH-1

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit, so that the count reaching WIDTH on the final
  // increment cannot wrap.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-adder cell working on the current LSBs.
  logic bit_s;
  logic bit_c;

  assign bit_s = a_reg[0] ^ b_reg[0] ^ carry;
  assign bit_c = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));

  // busy and done are registered. Each is set from the state being entered,
  // so busy is high exactly in SHIFT and done is high exactly in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // sum and cout keep the previous result until the shifting overwrites them.
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        SHIFT: begin
          // start is deliberately not examined here.
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          sum   <= {bit_s, sum[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= bit_c;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8

module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_vec;
  int n_err;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with the DUT idle. Presents the operands with start
  // for one cycle, counts busy cycles up to done, checks the result, the one-cycle done
  // pulse and that the result holds afterwards. Returns one cycle after done, at a negedge.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec);
    int busy_cnt;
    int wait_cnt;
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    wait_cnt = 0;
    while (!done && wait_cnt < 40) begin
      if (busy) busy_cnt++;
      wait_cnt++;
      @(negedge clk);
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_hold", 32'({cout, sum}), 32'({ec, es}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         bad;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] model;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
    vecs[7] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[8] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0};
    vecs[9] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, sum: 8'hFF, cout: 1'b0};

    // Reset state, with start undriven meanwhile.
    rst_n = 1'b0;
    start = 1'bx;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Release and start in the same cycle: the first edge after release accepts.
    rst_n = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // Table of directed vectors.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // start pulsed in SHIFT cycle 3 with new operands must be ignored.
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      if (k == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'hAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("ignore_done_time", 32'(k), 32'd9);
    check("ignore_sum", 32'(sum), 32'h46);
    check("ignore_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // Back-to-back: start held through DONE, accepted without an IDLE cycle.
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_sum", 32'({cout, sum}), 32'h003);
    a     = 8'h80;
    b     = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_busy", 32'(busy), 32'd1);
    check("b2b_no_idle_done", 32'(done), 32'd0);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_spacing", 32'(k), 32'd9);
    check("b2b_second_sum", 32'(sum), 32'h00);
    check("b2b_second_cout", 32'(cout), 32'd1);
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(done), 32'd0);

    // Reset in SHIFT cycle 4: outputs clear at once, no done pulse follows.
    a     = 8'h55;
    b     = 8'h0F;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("no_activity_after_rst", 32'(bad), 32'd0);
    run_op(8'h03, 8'h05, 1'b0, 8'h08, 1'b0);

    // Random sweep against a 9-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rc    = 1'($urandom_range(0, 1));
      model = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(ra, rb, rc, model[7:0], model[8]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-006 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 cin  input  1  carry-in; captured on the accepting edge.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse marking that the result is complete.
REQ-011 sum  output  WIDTH  result A+B+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
- On the accepting edge: a, b and cin are loaded into internal registers, the bit counter clears to 0, and the state goes to SHIFT.
REQ-015 start SHALL be ignored while in SHIFT.
- No recapture, no counter restart, no effect on the result.
REQ-016 On each edge in SHIFT, the block SHALL compute one full-adder bit, LSB first.
- s = a_reg[0] ^ b_reg[0] ^ c.
- c_next = (a_reg[0] & b_reg[0]) | (c & (a_reg[0] ^ b_reg[0])).
- a_reg and b_reg shift right by one; s shifts into sum at the MSB while sum shifts right; the carry flop takes c_next; the counter increments.
REQ-017 When the counter equals WIDTH-1 in SHIFT, the next edge SHALL process the final bit, load cout with c_next, and go to DONE.
REQ-018 Timing SHALL be fixed for an accepting edge E0:
- busy=1 from E0 through edge E0+WIDTH.
- done=1 for exactly the cycle following edge E0+WIDTH.
- Total latency is WIDTH cycles.
REQ-019 DONE SHALL last one cycle, then go to IDLE, unless start=1 on that edge, in which case a new operation is accepted and the state goes straight to SHIFT.
REQ-020 sum and cout SHALL hold the completed result unchanged in DONE and IDLE until the next accepting edge.
- Their values while busy=1 are not checked.
REQ-021 busy SHALL be a registered decode of state (busy=1 exactly in SHIFT); done SHALL be 1 exactly in DONE.
REQ-022 The counter SHALL be clog2(WIDTH)+1 bits and SHALL never wrap within an operation.
REQ-023 Arithmetic SHALL be unsigned; overflow is reported only via cout.
REQ-024 X on start while rst_n=0 SHALL have no effect.

Reset
REQ-025 When rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry flop, a_reg and b_reg.
REQ-026 Reset asserted mid-SHIFT SHALL abandon the operation with no done pulse.
- After release, the block idles until the next start.
REQ-027 The first edge after rst_n rises SHALL be able to accept start.

Verification (WIDTH=8)
REQ-028 Bench: a=0x0F, b=0x01, cin=0, start 1 cycle -> busy high 8 cycles, done pulse after 8th edge, sum=0x10, cout=0.
REQ-029 Bench: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 Bench: accept a=0x12, b=0x34; pulse start with a=0xAA, b=0xAA at cycle 3 of SHIFT -> ignored, done at the original time, sum=0x46, cout=0.
REQ-031 Bench: start held high through DONE with new a=0x80, b=0x80 -> back-to-back accept with no IDLE cycle, second result sum=0x00, cout=1, done pulses 9 cycles apart.
REQ-032 Bench: rst_n low for 1 cycle at SHIFT cycle 4 -> all outputs 0 asynchronously, no done pulse, next start a=0x03, b=0x05 -> sum=0x08.
REQ-033 Bench: random sweep of 1000 (a, b, cin) triples checked against (a+b+cin) -> {cout, sum} exact, done asserted exactly once per accepted start.
